syscall_console: RTL and testbench



---
 rtl/syscall_console.sv | 129 ++++++++++++
 tb/tb_syscall_console.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/syscall_console.sv
// syscall_console: buffered display FIFO plus exit sequencer for the syscall
// decode stage. Display words are queued and drained through a valid/ready
// sink port; an exit request waits for the queue to empty, then raises a
// sticky halt that only reset clears.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. Syscall side: sys_valid/sys_ready (stall = sys_valid && !sys_ready).
// Sink side: out_valid/out_ready; out_data is held stable while out_valid is
// high and out_ready is low.
module syscall_console #(
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sys_valid,
    input  logic [31:0]   sys_code,
    input  logic [31:0]   sys_arg,
    output logic          sys_ready,
    output logic          stall,
    output logic          out_valid,
    output logic [31:0]   out_data,
    input  logic          out_ready,
    output logic [CW-1:0] count,
    output logic          halt,
    output logic [1:0]    dbg_state
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [31:0] CODE_DISPLAY = 32'd1;
    localparam logic [31:0] CODE_EXIT    = 32'd2;

    logic [1:0]    r_state;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_out_data;
    logic [31:0]   r_mem [DEPTH];

    logic          w_full;
    logic          w_empty;
    logic          w_accept;
    logic          w_push;
    logic          w_exit;
    logic          w_pop;
    logic [CW-1:0] w_count_next;
    logic [AW-1:0] w_rd_next;
    logic [31:0]   w_head_next;
    logic [1:0]    w_state_next;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);

    assign sys_ready = (r_state == ST_RUN) && !w_full;
    assign stall     = sys_valid && !sys_ready;
    assign out_valid = !w_empty && (r_state != ST_HALTED);
    assign out_data  = r_out_data;
    assign count     = r_count;
    assign halt      = (r_state == ST_HALTED);
    assign dbg_state = r_state;

    assign w_accept  = sys_valid && sys_ready;
    assign w_push    = w_accept && (sys_code == CODE_DISPLAY);
    assign w_exit    = w_accept && (sys_code == CODE_EXIT);
    assign w_pop     = out_valid && out_ready;

    assign w_rd_next = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;

    // Next head word: if the slot the head moves to is being written this
    // cycle (empty FIFO, or a single entry popped while pushing), bypass the
    // incoming word; otherwise the slot already holds valid data.
    assign w_head_next = (w_push && (w_rd_next == r_wr_ptr)) ? sys_arg : r_mem[w_rd_next];

    // Occupancy update: +1 push only, -1 pop only, unchanged otherwise.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Sequencer: exit moves to DRAIN; DRAIN halts once the queue will be empty.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:    if (w_exit) w_state_next = ST_DRAIN;
            ST_DRAIN:  if (w_count_next == '0) w_state_next = ST_HALTED;
            ST_HALTED: w_state_next = ST_HALTED;
            default:   w_state_next = ST_RUN;
        endcase
    end

    // Control registers: pointers, occupancy, state and the presented word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_out_data <= '0;
        end else begin
            r_state  <= w_state_next;
            r_count  <= w_count_next;
            r_rd_ptr <= w_rd_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            // With an empty queue the last presented word is kept.
            if (w_count_next != '0) begin
                r_out_data <= w_head_next;
            end
        end
    end

    // Storage array; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= sys_arg;
        end
    end

endmodule

// File: tb/tb_syscall_console.sv
// Bench for syscall_console: directed scenarios followed by a randomized
// phase, each cycle compared against a queue-based reference model.
module tb_syscall_console;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          sys_valid;
    logic [31:0]   sys_code;
    logic [31:0]   sys_arg;
    logic          sys_ready;
    logic          stall;
    logic          out_valid;
    logic [31:0]   out_data;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          halt;
    logic [1:0]    dbg_state;

    // Reference model: pending display words, exit/halt flags, last word shown.
    logic [31:0] exp_q[$];
    bit          m_exiting;
    bit          m_halted;
    logic [31:0] m_last;
    bit          last_accept;

    int n_pass  = 0;
    int n_total = 0;

    // Clock block.
    always #5 clk = ~clk;

    syscall_console #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .sys_valid (sys_valid),
        .sys_code  (sys_code),
        .sys_arg   (sys_arg),
        .sys_ready (sys_ready),
        .stall     (stall),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .halt      (halt),
        .dbg_state (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_exiting = 1'b0;
        m_halted  = 1'b0;
        m_last    = 32'd0;
    endtask

    // Drive one cycle, compare all outputs against the model, advance model.
    task automatic cycle(input logic v, input logic [31:0] code, input logic [31:0] arg,
                         input logic rdy);
        bit          e_ready;
        bit          e_ovalid;
        bit          acc;
        bit          pop;
        bit          was_exiting;
        logic [31:0] e_data;
        sys_valid = v;
        sys_code  = code;
        sys_arg   = arg;
        out_ready = rdy;
        #1;
        e_ready  = !m_exiting && !m_halted && (exp_q.size() < DEPTH);
        e_ovalid = (exp_q.size() != 0) && !m_halted;
        e_data   = (exp_q.size() != 0) ? exp_q[0] : m_last;
        chk("sys_ready", 32'(sys_ready), 32'(e_ready));
        chk("stall",     32'(stall),     32'(v && !e_ready));
        chk("out_valid", 32'(out_valid), 32'(e_ovalid));
        chk("out_data",  out_data,       e_data);
        chk("count",     32'(count),     32'(exp_q.size()));
        chk("halt",      32'(halt),      32'(m_halted));
        acc         = v && e_ready;
        pop         = e_ovalid && rdy;
        was_exiting = m_exiting;
        last_accept = acc;
        @(posedge clk);
        if (pop) m_last = exp_q.pop_front();
        if (acc && code == 32'd1) exp_q.push_back(arg);
        if (acc && code == 32'd2) m_exiting = 1'b1;
        if (was_exiting && exp_q.size() == 0) begin
            m_halted  = 1'b1;
            m_exiting = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        sys_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 32'd0, rdy);
    endtask

    initial begin
        int          tries;
        int          r;
        logic [31:0] code;
        reset     = 1'b1;
        sys_valid = 1'b0;
        sys_code  = 32'd0;
        sys_arg   = 32'd0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Reset values, then three back-to-back displays into a live sink.
        idle(1, 1'b0);
        cycle(1'b1, 32'd1, 32'h11, 1'b1);
        cycle(1'b1, 32'd1, 32'h22, 1'b1);
        cycle(1'b1, 32'd1, 32'h33, 1'b1);
        idle(2, 1'b1);

        // Overfill with a stalled sink, then release it.
        for (int i = 1; i <= 9; i++) cycle(1'b1, 32'd1, 32'(i), 1'b0);
        tries = 0;
        do begin
            cycle(1'b1, 32'd1, 32'd9, 1'b1);
            tries++;
        end while (!last_accept && tries < 5);
        chk("full_reopen_cycles", 32'(tries), 32'd2);
        idle(10, 1'b1);

        // Queue three words, exit, hold the sink for four cycles, then drain.
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'd1, 32'h100 + 32'(i), 1'b0);
        cycle(1'b1, 32'd2, 32'd0, 1'b0);
        idle(4, 1'b0);
        idle(5, 1'b1);
        chk("halt_after_drain", 32'(halt), 32'd1);

        // Exit on an empty queue followed by a display that must stall.
        do_reset();
        cycle(1'b1, 32'd2, 32'd0, 1'b1);
        cycle(1'b1, 32'd1, 32'h55, 1'b1);
        idle(2, 1'b1);

        // Nop interleaved with displays.
        do_reset();
        cycle(1'b1, 32'd1, 32'hA, 1'b1);
        cycle(1'b1, 32'd7, 32'hDEAD, 1'b1);
        cycle(1'b1, 32'd1, 32'hB, 1'b1);
        idle(3, 1'b1);

        // Reset in the middle of a drain with five words queued.
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'd1, 32'h200 + 32'(i), 1'b0);
        cycle(1'b1, 32'd2, 32'd0, 1'b0);
        idle(1, 1'b0);
        do_reset();
        cycle(1'b1, 32'd1, 32'h1, 1'b1);
        idle(2, 1'b1);

        // Randomized traffic, resetting some time after each halt.
        for (int i = 0; i < 600; i++) begin
            if (m_halted && $urandom_range(0, 3) == 0) begin
                do_reset();
            end else begin
                r = $urandom_range(0, 29);
                if (r < 20)       code = 32'd1;
                else if (r == 20) code = 32'd2;
                else if (r < 24)  code = 32'd0;
                else if (r < 27)  code = 32'd7;
                else              code = $urandom;
                cycle($urandom_range(0, 3) != 0, code, $urandom, $urandom_range(0, 2) != 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
